// File: rtl/dsram_resp_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dsram_resp_pkg;

    // One response-queue entry: {is_wr, data[31:0], cnt[2:0]}
    localparam int          DSRAM_ENTRY_WD   = 36;
    localparam logic [15:0] DSRAM_LFSR_SEED  = 16'hACE1;
    localparam int          DSRAM_ADDR_WIDTH = 16;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
        logic [2:0]  cnt;
    } dsram_entry_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] dsram_lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order response queue; each entry counts down to its data_ok cycle.
// Latency: a pushed entry reaches cnt==0 LATENCY-1 edges after the push.
// Backpressure: full_o is registered state only; the caller must not push when full.
//
// Ports: push_i/push_is_wr_i/push_data_i load a new tail entry; pop_i removes
// the head; full_o, head_vld_o, head_is_wr_o, head_data_o, head_cnt_o expose
// the queue state to the top.
module dsram_resp_fifo
    import dsram_resp_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push_i,
    input  logic        push_is_wr_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        head_vld_o,
    output logic        head_is_wr_o,
    output logic [31:0] head_data_o,
    output logic [2:0]  head_cnt_o
);

    // Slot OUTSTANDING is a permanently empty spare so the shift never
    // reads past the end of the array.
    dsram_entry_t           ent_q [OUTSTANDING+1];
    dsram_entry_t           ent_d [OUTSTANDING+1];
    logic [OUTSTANDING:0]   vld_q, vld_d;
    logic [2:0]             count_q, count_d;
    logic [2:0]             wr_ptr;

    always_comb begin
        vld_d = '0;
        for (int i = 0; i <= OUTSTANDING; i++) ent_d[i] = '0;
        // Tail slot after this cycle's pop has been accounted for.
        wr_ptr = count_q - {2'b00, pop_i};
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (pop_i) begin
                vld_d[i] = vld_q[i+1];
                ent_d[i] = ent_q[i+1];
            end else begin
                vld_d[i] = vld_q[i];
                ent_d[i] = ent_q[i];
            end
            if (vld_d[i] && ent_d[i].cnt != 3'd0) begin
                ent_d[i].cnt = ent_d[i].cnt - 3'd1;
            end
            if (push_i && wr_ptr == 3'(i)) begin
                vld_d[i]       = 1'b1;
                ent_d[i].is_wr = push_is_wr_i;
                ent_d[i].data  = push_data_i;
                ent_d[i].cnt   = 3'(LATENCY - 1);
            end
        end
        count_d = count_q + {2'b00, push_i} - {2'b00, pop_i};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q   <= '0;
            count_q <= 3'd0;
            for (int i = 0; i <= OUTSTANDING; i++) ent_q[i] <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int i = 0; i <= OUTSTANDING; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign full_o       = (count_q == 3'(OUTSTANDING));
    assign head_vld_o   = vld_q[0];
    assign head_is_wr_o = ent_q[0].is_wr;
    assign head_data_o  = ent_q[0].data;
    assign head_cnt_o   = ent_q[0].cnt;

endmodule

// File: rtl/dsram_resp.sv
// SRAM-like data responder: word memory plus in-order fixed-latency responses.
// Latency: data_ok LATENCY cycles after the accepting edge (1 => next cycle).
// Backpressure: addr_ok drops while OUTSTANDING requests are pending; data_ok cannot be stalled.
//
// Ports: clk, resetn (sync, active low); data_sram_req/wr/wen/addr/wdata in;
// data_sram_addr_ok, data_sram_data_ok, data_sram_rdata out.
// Optional macro DSRAM_RAND_STALL_EN: an LFSR randomly withholds addr_ok.
module dsram_resp
    import dsram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = DSRAM_ADDR_WIDTH,
    parameter int LATENCY     = 1,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           rd_word;
    logic                  hold;
    logic                  accept;
    logic                  full;
    logic                  head_vld;
    logic                  head_is_wr;
    logic [31:0]           head_data;
    logic [2:0]            head_cnt;
    logic                  unused_addr_bits;

    assign widx             = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!resetn) lfsr_q <= DSRAM_LFSR_SEED;
        else         lfsr_q <= dsram_lfsr_next(lfsr_q);
    end

    assign hold = lfsr_q[0];
`else
    assign hold = 1'b0;
`endif

    // Full is judged on the registered count only, so a same-cycle pop does
    // not open the slot; this keeps data_ok out of the addr_ok path.
    assign data_sram_addr_ok = data_sram_req && !full && !hold;
    assign accept            = data_sram_addr_ok;

    // Memory is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[widx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Reads capture the word at acceptance; earlier writes have already landed.
    assign rd_word = mem[widx];

    dsram_resp_fifo #(
        .OUTSTANDING (OUTSTANDING),
        .LATENCY     (LATENCY)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (accept),
        .push_is_wr_i (data_sram_wr),
        .push_data_i  (data_sram_wr ? 32'h0 : rd_word),
        .pop_i        (data_sram_data_ok),
        .full_o       (full),
        .head_vld_o   (head_vld),
        .head_is_wr_o (head_is_wr),
        .head_data_o  (head_data),
        .head_cnt_o   (head_cnt)
    );

    assign data_sram_data_ok = head_vld && (head_cnt == 3'd0);
    assign data_sram_rdata   = (data_sram_data_ok && !head_is_wr) ? head_data : 32'h0;

endmodule

// File: tb/tb_dsram_resp.sv
`timescale 1ns/1ps
module tb_dsram_resp;

    localparam int AW    = 16;
    localparam int OUTS  = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int NPRE  = 16;
    localparam int NRAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        req   [2];
    logic        wr    [2];
    logic [3:0]  wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata   [2];

    dsram_resp #(.ADDR_WIDTH(AW), .LATENCY(LAT_A), .OUTSTANDING(OUTS)) dut_a (
        .clk(clk), .resetn(resetn),
        .data_sram_req(req[0]), .data_sram_wr(wr[0]), .data_sram_wen(wen[0]),
        .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]),
        .data_sram_rdata(rdata[0])
    );

    dsram_resp #(.ADDR_WIDTH(AW), .LATENCY(LAT_B), .OUTSTANDING(OUTS)) dut_b (
        .clk(clk), .resetn(resetn),
        .data_sram_req(req[1]), .data_sram_wr(wr[1]), .data_sram_wen(wen[1]),
        .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]),
        .data_sram_rdata(rdata[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    // Pending responses: the cycle number in which data_ok is due plus the data.
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    pend_t       mq [2][$];
    logic [31:0] mmem [int];
    int          cyc = 0;
    bit          acc [2];
    int          ngen [2];
    int          nacc [2];
`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] mlfsr = 16'hACE1;
    int          stall_seen = 0;
`endif

    function automatic int lat(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int mkey(input int d, input logic [31:0] a);
        return d * (1 << AW) + int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    endfunction

    function automatic bit m_hold();
`ifdef DSRAM_RAND_STALL_EN
        return mlfsr[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_aok(input int d);
        return req[d] && (mq[d].size() < OUTS) && !m_hold();
    endfunction

    function automatic bit m_dok(input int d);
        return (mq[d].size() != 0) && (mq[d][0].due == cyc);
    endfunction

    function automatic logic [31:0] m_rd(input int d);
        return m_dok(d) ? mq[d][0].data : 32'h0;
    endfunction

    task automatic m_step();
        for (int d = 0; d < 2; d++) begin
            bit          o;
            bit          a;
            int          k;
            logic [31:0] w;
            pend_t       p;
            if (!resetn) begin
                mq[d].delete();
                acc[d] = 1'b0;
            end else begin
                o = m_dok(d);
                a = m_aok(d);
                acc[d] = a;
                if (o) void'(mq[d].pop_front());
                if (a) begin
                    k = mkey(d, addr[d]);
                    w = mmem.exists(k) ? mmem[k] : 32'h0;
                    p.due = cyc + lat(d);
                    if (wr[d]) begin
                        for (int b = 0; b < 4; b++)
                            if (wen[d][b]) w[8*b +: 8] = wdata[d][8*b +: 8];
                        mmem[k] = w;
                        p.data = 32'h0;
                    end else begin
                        p.data = w;
                    end
                    mq[d].push_back(p);
                end
            end
        end
`ifdef DSRAM_RAND_STALL_EN
        if (!resetn) mlfsr = 16'hACE1;
        else         mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
`endif
        cyc++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a negedge with inputs already driven; ends at the next negedge.
    task automatic cycle(input bit chk_en);
        #2;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("mdl_addr_ok[%0d]", d), 32'(addr_ok[d]), 32'(m_aok(d)));
                chk($sformatf("mdl_data_ok[%0d]", d), 32'(data_ok[d]), 32'(m_dok(d)));
                chk($sformatf("mdl_rdata[%0d]", d), rdata[d], m_rd(d));
`ifdef DSRAM_RAND_STALL_EN
                if (req[d] && mq[d].size() < OUTS && !addr_ok[d]) stall_seen++;
`endif
            end
        end
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        req[d] = r; wr[d] = w; wen[d] = be; addr[d] = a; wdata[d] = wd;
    endtask

    task automatic gen(input int d);
        int idx;
        if (ngen[d] < NPRE) begin
            drive(d, 1'b1, 1'b1, 4'hF, 32'(ngen[d]) << 2, $urandom());
            ngen[d]++;
        end else begin
            idx = $urandom_range(0, 15);
            drive(d, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom()),
                  ($urandom() & 32'hFFFC_0003) | (32'(idx) << 2), $urandom());
        end
    endtask

    // ---------------- directed vectors for the LATENCY=1 instance ----------------
    typedef struct {
        logic        rq;
        logic        w;
        logic [3:0]  be;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        eaok;
        logic        edok;
        logic [31:0] erd;
    } vec_t;

    vec_t tv [13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ea [8];
        bit ed [8];
        bit budget_ok;

        resetn = 1'b0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset then idle: state is unknown before the first reset edge.
        cycle(1'b0);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_addr_ok[%0d]", d), 32'(addr_ok[d]), 32'h0);
            chk($sformatf("rst_data_ok[%0d]", d), 32'(data_ok[d]), 32'h0);
            chk($sformatf("rst_rdata[%0d]", d), rdata[d], 32'h0);
        end
        cycle(1'b1);
        resetn = 1'b1;
        cycle(1'b1);

`ifndef DSRAM_RAND_STALL_EN
        tv[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 32'h0};
        tv[2]  = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        tv[3]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 1'b1, 4'h5, 32'h0000_0200, 32'hAABB_CCDD, 1'b1, 1'b1, 32'h0};
        tv[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0,         1'b1, 1'b1, 32'h0};
        tv[6]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0200, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h11BB_33DD};
        tv[7]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0203, 32'h0,         1'b1, 1'b1, 32'h0};
        tv[8]  = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h11BB_33DD};
        tv[9]  = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
        tv[10] = '{1'b1, 1'b0, 4'h0, 32'hFFFC_0100, 32'h0,         1'b1, 1'b0, 32'h0};
        tv[11] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        tv[12] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
        for (int i = 0; i < 13; i++) begin
            drive(0, tv[i].rq, tv[i].w, tv[i].be, tv[i].ad, tv[i].wd);
            #1;
            chk($sformatf("tbl%0d_addr_ok", i), 32'(addr_ok[0]), 32'(tv[i].eaok));
            chk($sformatf("tbl%0d_data_ok", i), 32'(data_ok[0]), 32'(tv[i].edok));
            chk($sformatf("tbl%0d_rdata", i), rdata[0], tv[i].erd);
            cycle(1'b1);
        end

        // Full stall on the LATENCY=3 instance with req held high.
        drive(1, 1'b1, 1'b1, 4'hF, 32'h0000_0300, 32'h5A5A_0F0F);
        cycle(1'b1);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1);
        ea = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("full%0d_addr_ok", i), 32'(addr_ok[1]), 32'(ea[i]));
            chk($sformatf("full%0d_data_ok", i), 32'(data_ok[1]), 32'(ed[i]));
            chk($sformatf("full%0d_rdata", i), rdata[1], ed[i] ? 32'h5A5A_0F0F : 32'h0);
            cycle(1'b1);
        end
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b1);

        // Reset mid-flight: two reads accepted, reset before either answers.
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("mid%0d_addr_ok", i), 32'(addr_ok[1]), 32'h1);
            cycle(1'b1);
        end
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("midrst%0d_data_ok", i), 32'(data_ok[1]), 32'h0);
            cycle(1'b1);
        end
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("postrst%0d_data_ok", i), 32'(data_ok[1]), 32'h0);
            cycle(1'b1);
        end
        // Count must be back at zero: two consecutive accepts are possible.
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("postrst_acc%0d", i), 32'(addr_ok[1]), 32'h1);
            cycle(1'b1);
        end
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b1);
`endif

        // Randomized traffic on both instances against the model.
        for (int d = 0; d < 2; d++) begin
            ngen[d] = 0;
            nacc[d] = 0;
            gen(d);
        end
        budget_ok = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            cycle(1'b1);
            for (int d = 0; d < 2; d++) begin
                if (acc[d]) begin
                    nacc[d]++;
                    gen(d);
                end else if (!req[d]) begin
                    gen(d);
                end
            end
            if (nacc[0] >= NPRE + NRAND && nacc[1] >= NPRE + NRAND) begin
                budget_ok = 1'b1;
                break;
            end
        end
        chk("rand_budget", 32'(budget_ok), 32'h1);
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1);
        for (int d = 0; d < 2; d++)
            chk($sformatf("drained[%0d]", d), 32'(mq[d].size()), 32'h0);

`ifdef DSRAM_RAND_STALL_EN
        chk("stall_seen", 32'(stall_seen != 0), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dsram_resp.md
# dsram_resp

Responder end of the SRAM-like data interface driven by the execute stage (`data_sram_req/wr/wen/addr/wdata` with `addr_ok`, `data_ok` and `rdata`). It accepts requests and holds a word-addressed backing memory. It returns in-order `data_ok`/`rdata` responses after a fixed latency and supports a bounded number of outstanding transactions. It sits in the simulation/FPGA SoC in place of the data-side cache/AXI bridge, so memory-stage pipelining can be exercised against a real handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 1: cycles from acceptance edge to `data_ok`; legal range 1..7.
- `OUTSTANDING`, default 2: maximum accepted but not yet answered requests; legal range 1..4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `data_sram_req` in 1: request valid.
- `data_sram_wr` in 1: 1 = write, 0 = read.
- `data_sram_wen` in 4: byte enables; only used when `wr`=1.
- `data_sram_addr` in 32: byte address; the word index is `addr[ADDR_WIDTH+1:2]`, and the other bits are ignored.
- `data_sram_wdata` in 32: write data, with lane i = bits [8i+7:8i].
- `data_sram_addr_ok` out 1: request accepted this cycle.
- `data_sram_data_ok` out 1: response for the oldest outstanding request.
- `data_sram_rdata` out 32: read data, valid only with `data_ok`.

## Operation
- Accept condition: `req && addr_ok`. `addr_ok = req && (count != OUTSTANDING) && !hold`.
  - `hold` is 0 unless the configuration feature is enabled.
  - `addr_ok` is combinational from `req` and registered state only.
- Memory accesses happen on the acceptance edge:
  - Write: bytes with `wen[i]`=1 are updated.
  - Read: the addressed word is captured into the new queue entry.
  - Ordering: a read accepted after a write to the same word returns the new data.
- Queue: in-order FIFO of `OUTSTANDING` entries. Each entry holds {`is_wr`, `data[31:0]`, `cnt[2:0]`}.
  - Push sets `cnt=LATENCY-1`.
  - Every cycle, each valid entry with `cnt!=0` decrements.
- Response: `data_ok = head_valid && head.cnt==0`. The head pops in the same cycle. There is no backpressure on `data_ok`; the requester must always sink it.
- `rdata`: `head.data` for reads; 32'h0 for writes and whenever `data_ok`=0.
- Full: `count==OUTSTANDING` deasserts `addr_ok` even if a pop happens in the same cycle. This keeps the path from `data_ok` to `addr_ok` short.
- Simultaneous push and pop while not full: `count` is unchanged and both take effect.
- No error responses. Misaligned addresses and `wen`=0 writes complete normally; a `wen`=0 write leaves memory unchanged.

## Timing
- Reset (`resetn`=0 at an edge):
  - Queue empties and `count` goes to 0.
  - `addr_ok`=0, `data_ok`=0, `rdata`=0 in the following cycle.
  - Memory contents are not reset.
  - Reset mid-operation discards pending responses; no `data_ok` is issued for them.
- Latency: a request accepted at edge k produces `data_ok` high in the cycle after edge k+LATENCY-1. With `LATENCY`=1, `data_ok` comes in the cycle immediately after acceptance.
- Throughput: one accept per cycle while not full. With `LATENCY`=1 and `OUTSTANDING`>=2, back-to-back requests sustain 1 per cycle.
- `wdata`/`wen`/`addr` are sampled only on the acceptance edge.

## Configuration
- `DSRAM_RAND_STALL_EN`, when defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - `hold = lfsr[0]`, which randomly withholds `addr_ok` to stress requester stall paths.
- Undefined: `hold`=0; the LFSR is not instantiated.

## Structure
- `mycpu.h` gains:
  - `DSRAM_ENTRY_WD` (entry width, 36).
  - `DSRAM_LFSR_SEED`.
  - Default `DSRAM_ADDR_WIDTH`.
- One sub-module, `dsram_resp_fifo`, holds the in-order response queue with per-entry countdown. It has push/pop/full/head ports and is parameterized by `OUTSTANDING` and `LATENCY`.
- Memory array, accept logic and the optional LFSR live in the top.

## Test plan
- Reset then idle: `resetn`=0 for 2 cycles, `req`=0 -> `addr_ok`=0, `data_ok`=0, `rdata`=0.
- Write then read, `LATENCY`=1:
  - Write addr 0x100, wdata 0xDEADBEEF, wen 4'hF.
  - Read 0x100 on the next cycle.
  - Expect `data_ok` 1 cycle after each accept; read `rdata`=0xDEADBEEF.
- Byte enables:
  - Preload 0x11223344 at 0x200.
  - Write wdata 0xAABBCCDD, wen 4'b0101.
  - Read -> 0x11BB33DD.
- Full stall, `LATENCY`=3, `OUTSTANDING`=2, `req` held high:
  - Two accepts on consecutive cycles, then `addr_ok`=0.
  - Next accept occurs the cycle after the first `data_ok`.
  - Responses arrive in order.
- Reset mid-flight: accept 2 reads, assert `resetn`=0 before any `data_ok` -> no `data_ok` afterwards and `count`=0.
- With `DSRAM_RAND_STALL_EN`:
  - 1000 random reads/writes against a scoreboard: every response matches the model and arrives in order.
  - `addr_ok` is low at least once while `req`=1 and not full.
